// File: rtl/nn_pkg.sv
// nn_pkg - shared definitions for the sequential fully-connected layer.
//   MODE_STEP / MODE_RELU / MODE_LIN : activation selectors (2'd3 is also linear)
//   nn_state_t                       : layer controller states
//   acc_width(dw, n_in)              : accumulator width that holds b + sum(w*x)
//                                      without overflow
package nn_pkg;

    localparam logic [1:0] MODE_STEP = 2'd0;
    localparam logic [1:0] MODE_RELU = 2'd1;
    localparam logic [1:0] MODE_LIN  = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        LOAD    = 2'd1,
        READY   = 2'd2,
        COMPUTE = 2'd3
    } nn_state_t;

    // N_IN products of two DW-bit values plus one DW-bit bias fit in
    // 2*DW + clog2(N_IN+1) bits; one spare bit keeps the comparison and
    // subtraction against the threshold trivially safe.
    function automatic int acc_width(input int dw, input int n_in);
        return 2 * dw + $clog2(n_in + 1) + 1;
    endfunction

endpackage

// File: rtl/nn_layer_seq_if.sv
// nn_layer_seq_if - host-side bus of the sequential neural layer.
//   data_in / data_valid / load_inputs_only : serial parameter/input load
//   changes / mode                          : start pulse and activation select
//   selector_output / network_outputs       : neuron result read-back
//   busy / done                             : status
// Modports: master = host/bench, slave = nn_layer_seq.
interface nn_layer_seq_if #(
    parameter int DW    = 8,
    parameter int SEL_W = 2
);
    logic [DW-1:0]    data_in;
    logic             data_valid;
    logic             load_inputs_only;
    logic             changes;
    logic [1:0]       mode;
    logic [SEL_W-1:0] selector_output;
    logic [DW-1:0]    network_outputs;
    logic             busy;
    logic             done;

    modport master (
        output data_in, data_valid, load_inputs_only, changes, mode, selector_output,
        input  network_outputs, busy, done
    );

    modport slave (
        input  data_in, data_valid, load_inputs_only, changes, mode, selector_output,
        output network_outputs, busy, done
    );
endinterface

// File: rtl/nn_mac_unit.sv
// nn_mac_unit - time-shared multiply-accumulate plus activation.
//   clk, rst         : clock, asynchronous active-high reset
//   mac_en           : perform acc <= (mac_first ? b : acc) + w*x this cycle
//   mac_first        : first product of a neuron, the bias seeds the sum
//   w, x, b, th      : current weight, input, bias and threshold
//   mode             : activation select
//   act              : activation of the current accumulator (combinational)
module nn_mac_unit
    import nn_pkg::*;
#(
    parameter int DW   = 8,
    parameter int N_IN = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          mac_en,
    input  logic          mac_first,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] x,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] th,
    input  logic [1:0]    mode,
    output logic [DW-1:0] act
);

    localparam int AW = acc_width(DW, N_IN);
    localparam logic [AW-1:0] SAT_MAX = AW'({DW{1'b1}});

    logic [AW-1:0] acc_reg;
    logic [AW-1:0] base;
    logic [AW-1:0] prod;
    logic [AW-1:0] th_ext;
    logic [AW-1:0] diff;

    function automatic logic [DW-1:0] sat(input logic [AW-1:0] v);
        return (v > SAT_MAX) ? {DW{1'b1}} : v[DW-1:0];
    endfunction

    // Folding the bias into the first step saves a separate load cycle.
    assign base   = mac_first ? AW'(b) : acc_reg;
    assign prod   = AW'(w) * AW'(x);
    assign th_ext = AW'(th);
    // Only used when acc_reg > th_ext, so it never wraps.
    assign diff   = acc_reg - th_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_reg <= '0;
        end else if (mac_en) begin
            acc_reg <= base + prod;
        end
    end

    always_comb begin
        act = '0;
        case (mode)
            MODE_STEP: act = (acc_reg > th_ext) ? DW'(1) : '0;
            MODE_RELU: act = (acc_reg > th_ext) ? sat(diff) : '0;
            MODE_LIN:  act = sat(acc_reg);
            default:   act = sat(acc_reg);
        endcase
    end

endmodule

// File: rtl/nn_layer_seq.sv
// nn_layer_seq - parametrised fully-connected layer evaluated by one MAC.
//   clk    : rising-edge clock
//   reset  : asynchronous active-high reset, clears parameters and results
//   bus    : nn_layer_seq_if.slave (serial load, start, result select, status)
// Load order: x[N_IN-1]..x[0], then per neuron k = N_NEUR-1..0:
// th_k, b_k, w_k[N_IN-1]..w_k[0]. Each neuron takes N_IN MAC cycles plus one
// activation cycle; all results are committed together on the done cycle.
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int N_IN   = 4,
    parameter int N_NEUR = 4,
    parameter int DW     = 8
) (
    input  logic           clk,
    input  logic           reset,
    nn_layer_seq_if.slave  bus
);

    localparam int SEL_W = (N_NEUR > 1) ? $clog2(N_NEUR) : 1;
    localparam int SEL_N = 1 << SEL_W;
    localparam int XI_W  = $clog2(N_IN);
    localparam int OFF_W = $clog2(N_IN + 2);
    localparam int SW    = $clog2(N_IN + 1);

    localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(N_IN + 1);
    localparam logic [SW-1:0]    STEP_ACT = SW'(N_IN);
    localparam logic [XI_W-1:0]  XI_TOP   = XI_W'(N_IN - 1);
    localparam logic [SEL_W-1:0] K_TOP    = SEL_W'(N_NEUR - 1);

    nn_state_t        state_reg;
    logic [DW-1:0]    x_reg      [N_IN];
    logic [DW-1:0]    w_reg      [N_NEUR][N_IN];
    logic [DW-1:0]    b_reg      [N_NEUR];
    logic [DW-1:0]    th_reg     [N_NEUR];
    logic [DW-1:0]    shadow_reg [N_NEUR];
    logic [DW-1:0]    result_reg [N_NEUR];
    logic             ld_x_reg;      // still loading the x words
    logic             ld_only_reg;   // current load is inputs-only
    logic [XI_W-1:0]  ld_xi_reg;
    logic [SEL_W-1:0] ld_k_reg;
    logic [OFF_W-1:0] ld_off_reg;    // 0 = th, 1 = b, 2.. = weights
    logic [SW-1:0]    step_reg;      // 0..N_IN-1 MAC, N_IN activation
    logic [SEL_W-1:0] neur_reg;
    logic [1:0]       mode_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             mac_en;
    logic             mac_first;
    logic [XI_W-1:0]  mac_idx;
    logic [XI_W-1:0]  w_idx;
    logic [DW-1:0]    act;
    logic [DW-1:0]    out_tab [SEL_N];

    assign mac_en    = (state_reg == COMPUTE) && (step_reg != STEP_ACT);
    assign mac_first = (step_reg == '0);
    // On the activation step the index wraps harmlessly; mac_en is low.
    assign mac_idx   = step_reg[XI_W-1:0];
    // Weights arrive highest index first: offset 2 -> w[N_IN-1].
    assign w_idx     = XI_W'(OFF_LAST - ld_off_reg);

    nn_mac_unit #(
        .DW   (DW),
        .N_IN (N_IN)
    ) u_mac (
        .clk       (clk),
        .rst       (reset),
        .mac_en    (mac_en),
        .mac_first (mac_first),
        .w         (w_reg[neur_reg][mac_idx]),
        .x         (x_reg[mac_idx]),
        .b         (b_reg[neur_reg]),
        .th        (th_reg[neur_reg]),
        .mode      (mode_reg),
        .act       (act)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            mode_reg    <= MODE_STEP;
            ld_x_reg    <= 1'b0;
            ld_only_reg <= 1'b0;
            ld_xi_reg   <= '0;
            ld_k_reg    <= '0;
            ld_off_reg  <= '0;
            step_reg    <= '0;
            neur_reg    <= '0;
            for (int i = 0; i < N_IN; i++) begin
                x_reg[i] <= '0;
            end
            for (int k = 0; k < N_NEUR; k++) begin
                b_reg[k]      <= '0;
                th_reg[k]     <= '0;
                shadow_reg[k] <= '0;
                result_reg[k] <= '0;
                for (int i = 0; i < N_IN; i++) begin
                    w_reg[k][i] <= '0;
                end
            end
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE, READY: begin
                    // A start in READY beats a simultaneous load word.
                    if (state_reg == READY && bus.changes) begin
                        state_reg <= COMPUTE;
                        busy_reg  <= 1'b1;
                        mode_reg  <= bus.mode;
                        step_reg  <= '0;
                        neur_reg  <= K_TOP;
                    end else if (bus.data_valid) begin
                        x_reg[XI_TOP] <= bus.data_in;
                        ld_xi_reg     <= XI_W'(N_IN - 2);
                        ld_x_reg      <= 1'b1;
                        ld_only_reg   <= bus.load_inputs_only;
                        state_reg     <= LOAD;
                        busy_reg      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.data_valid) begin
                        if (ld_x_reg) begin
                            x_reg[ld_xi_reg] <= bus.data_in;
                            if (ld_xi_reg == '0) begin
                                if (ld_only_reg) begin
                                    state_reg <= READY;
                                    busy_reg  <= 1'b0;
                                end else begin
                                    ld_x_reg   <= 1'b0;
                                    ld_k_reg   <= K_TOP;
                                    ld_off_reg <= '0;
                                end
                            end else begin
                                ld_xi_reg <= ld_xi_reg - 1'b1;
                            end
                        end else begin
                            if (ld_off_reg == '0) begin
                                th_reg[ld_k_reg] <= bus.data_in;
                            end else if (ld_off_reg == OFF_W'(1)) begin
                                b_reg[ld_k_reg] <= bus.data_in;
                            end else begin
                                w_reg[ld_k_reg][w_idx] <= bus.data_in;
                            end
                            if (ld_off_reg == OFF_LAST) begin
                                if (ld_k_reg == '0) begin
                                    state_reg <= READY;
                                    busy_reg  <= 1'b0;
                                end else begin
                                    ld_k_reg   <= ld_k_reg - 1'b1;
                                    ld_off_reg <= '0;
                                end
                            end else begin
                                ld_off_reg <= ld_off_reg + 1'b1;
                            end
                        end
                    end
                end
                COMPUTE: begin
                    if (step_reg == STEP_ACT) begin
                        shadow_reg[neur_reg] <= act;
                        step_reg             <= '0;
                        if (neur_reg == '0) begin
                            // Neuron 0 finishes now, so it bypasses the shadow.
                            result_reg[0] <= act;
                            for (int k = 1; k < N_NEUR; k++) begin
                                result_reg[k] <= shadow_reg[k];
                            end
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            state_reg <= READY;
                        end else begin
                            neur_reg <= neur_reg - 1'b1;
                        end
                    end else begin
                        step_reg <= step_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Pad the result table to a power of two so unused selector codes read 0.
    generate
        for (genvar gi = 0; gi < SEL_N; gi++) begin : g_out
            if (gi < N_NEUR) begin : g_used
                assign out_tab[gi] = result_reg[gi];
            end else begin : g_zero
                assign out_tab[gi] = '0;
            end
        end
    endgenerate

    assign bus.network_outputs = out_tab[bus.selector_output];
    assign bus.busy            = busy_reg;
    assign bus.done            = done_reg;

endmodule
